// File: rtl/ultrasonic_echo_emulator.sv
// ultrasonic_echo_emulator
//   Purpose : cycle-accurate stand-in for an HC-SR04 ranging sensor. A trigger held high
//             for at least TRIG_MIN_CYC cycles arms it. When the trigger falls, it emits
//             a 40 kHz transmit burst, then an echo pulse whose width is the sampled
//             dist_cycles, and then a hold-off period.
//   Ports   : clk, rst_n (async, active-low), trigger, dist_cycles[31:0] (sampled on the
//             qualified trigger fall) -> echo, burst, busy, trig_err (1-cycle), done (1-cycle)
//   Config  : ECHO_JITTER_EN adds lfsr[3:0] (16-bit Fibonacci LFSR) to each echo width,
//             clamped to ECHO_TIMEOUT_CYC. When it is undefined, the echo width is exact.
//   Latency : trigger fall -> echo rise = 1 + 16*BURST_HALF cycles; no backpressure.
`timescale 1ns/1ps
module ultrasonic_echo_emulator #(
  parameter int unsigned TRIG_MIN_CYC     = 500,
  parameter int unsigned BURST_HALF       = 625,
  parameter int unsigned ECHO_TIMEOUT_CYC = 1900000,
  parameter int unsigned HOLDOFF_CYC      = 2500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic [31:0] dist_cycles,
  output logic        echo,
  output logic        burst,
  output logic        busy,
  output logic        trig_err,
  output logic        done
);

  localparam logic [31:0] TRIG_MIN   = 32'(TRIG_MIN_CYC);
  localparam logic [31:0] BURST_LEN  = 32'(16 * BURST_HALF);
  localparam logic [31:0] HALF_LAST  = 32'(BURST_HALF - 1);
  localparam logic [31:0] TIMEOUT    = 32'(ECHO_TIMEOUT_CYC);
  localparam logic [31:0] HOLDOFF    = 32'(HOLDOFF_CYC);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_FALL = 3'd2,
    S_BURST     = 3'd3,
    S_ECHO      = 3'd4,
    S_HOLDOFF   = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] width_q, width_calc;
  logic [31:0] half_cnt, half_cnt_n;
  logic        trig_d;
  logic        accept;
  logic        echo_n, burst_n, done_n, trig_err_n;
  logic [31:0] base_width;

  // Zero or out-of-range distances mean "no object": use the timeout width.
  assign base_width = ((dist_cycles == 32'd0) || (dist_cycles > TIMEOUT)) ? TIMEOUT : dist_cycles;

`ifdef ECHO_JITTER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [32:0] jit_sum;

  // Fibonacci LFSR with taps 16,14,13,11. The echo width uses the value held before
  // this measurement's advance.
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign jit_sum    = {1'b0, base_width} + {29'd0, lfsr[3:0]};
  assign width_calc = (jit_sum > {1'b0, TIMEOUT}) ? TIMEOUT : jit_sum[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (accept) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end
`else
  assign width_calc = base_width;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 32'd0;
      width_q  <= 32'd0;
      half_cnt <= 32'd0;
      trig_d   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      half_cnt <= half_cnt_n;
      trig_d   <= trigger;
      if (accept) begin
        width_q <= width_calc;
      end
    end
  end

  // Next-state logic. The trigger is only considered in IDLE, ARM and WAIT_FALL.
  // trig_d tracks trigger in every state. A trigger that is still held high when
  // HOLDOFF ends therefore does not look like a new rising edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigger && !trig_d) begin
          cnt_n   = 32'd1;
          state_n = (TRIG_MIN <= 32'd1) ? S_WAIT_FALL : S_ARM;
        end
      end
      S_ARM: begin
        if (!trigger) begin
          cnt_n   = 32'd0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 32'd1;
          if (cnt_n >= TRIG_MIN) begin
            state_n = S_WAIT_FALL;
          end
        end
      end
      S_WAIT_FALL: begin
        if (!trigger) begin
          cnt_n   = 32'd0;
          accept  = 1'b1;
          state_n = S_BURST;
        end
      end
      S_BURST: begin
        cnt_n = cnt + 32'd1;
        if (cnt_n >= BURST_LEN) begin
          cnt_n   = 32'd0;
          state_n = S_ECHO;
        end
      end
      S_ECHO: begin
        cnt_n = cnt + 32'd1;
        if (cnt_n >= width_q) begin
          cnt_n   = 32'd0;
          state_n = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        cnt_n = cnt + 32'd1;
        if (cnt_n >= HOLDOFF) begin
          cnt_n   = 32'd0;
          state_n = S_IDLE;
        end
      end
      default: begin
        cnt_n   = 32'd0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Output logic. Each output is computed from the current and next state and is
  // registered below, so every pulse lines up with the state it belongs to.
  always_comb begin
    echo_n     = (state_n == S_ECHO);
    done_n     = (state == S_ECHO) && (state_n == S_HOLDOFF);
    trig_err_n = (state == S_ARM) && (state_n == S_IDLE);
    burst_n    = 1'b0;
    half_cnt_n = 32'd0;
    if (state_n == S_BURST) begin
      if (state != S_BURST) begin
        // The burst starts high in the first BURST cycle.
        burst_n    = 1'b1;
        half_cnt_n = 32'd0;
      end else if (half_cnt >= HALF_LAST) begin
        burst_n    = ~burst;
        half_cnt_n = 32'd0;
      end else begin
        burst_n    = burst;
        half_cnt_n = half_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo     <= 1'b0;
      burst    <= 1'b0;
      done     <= 1'b0;
      trig_err <= 1'b0;
    end else begin
      echo     <= echo_n;
      burst    <= burst_n;
      done     <= done_n;
      trig_err <= trig_err_n;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
`timescale 1ns/1ps
module tb_ultrasonic_echo_emulator;

  localparam int TRIG_MIN = 500;
  localparam int BH       = 4;
  localparam int TO       = 1000;
  localparam int HOLD     = 50;
  localparam int LAT      = 1 + 16 * BH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trigger;
  logic [31:0] dist_cycles;
  logic        echo, burst, busy, trig_err, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int exp_w[$];
  int exp_lat[$];
  int obs_w[$];
  int fall_cyc, rise_cyc, echo_fall_cyc;
  int burst_rises = 0;
  logic prev_echo = 1'b0;
  logic prev_burst = 1'b0;

`ifdef ECHO_JITTER_EN
  logic [15:0] lfsr_m = 16'hACE1;
`endif

  ultrasonic_echo_emulator #(
    .TRIG_MIN_CYC(TRIG_MIN), .BURST_HALF(BH),
    .ECHO_TIMEOUT_CYC(TO), .HOLDOFF_CYC(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .dist_cycles(dist_cycles),
    .echo(echo), .burst(burst), .busy(busy), .trig_err(trig_err), .done(done)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop one expectation at every falling edge of echo.
  always @(negedge clk) begin
    int w, l;
    if (burst && !prev_burst) burst_rises++;
    prev_burst = burst;
    if (done || trig_err) begin
      checks++;
      if ((done && trig_err) || (done && !(prev_echo && !echo))) begin
        errors++;
        $display("FAIL done_trig_err got done=%0b trig_err=%0b echo_fall=%0b want exclusive, done only at echo fall",
                 done, trig_err, prev_echo && !echo);
      end
    end
    if (echo && !prev_echo) rise_cyc = cyc;
    if (!echo && prev_echo) begin
      echo_fall_cyc = cyc;
      if (!rst_n) begin
        if (exp_w.size() > 0) begin
          void'(exp_w.pop_front());
          void'(exp_lat.pop_front());
        end
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL reset_no_done got %0b want 0", done);
        end
      end else if (exp_w.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_echo got width %0d want no echo", cyc - rise_cyc);
      end else begin
        w = exp_w.pop_front();
        l = exp_lat.pop_front();
        obs_w.push_back(cyc - rise_cyc);
        checks++;
        if ((cyc - rise_cyc) !== w) begin
          errors++;
          $display("FAIL echo_width got %0d want %0d", cyc - rise_cyc, w);
        end
        checks++;
        if ((rise_cyc - fall_cyc) !== l) begin
          errors++;
          $display("FAIL echo_latency got %0d want %0d", rise_cyc - fall_cyc, l);
        end
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL done_at_fall got %0b want 1", done);
        end
      end
    end
    prev_echo = echo;
  end

  function automatic int model_width(input int d);
    int b;
    b = (d == 0 || d > TO) ? TO : d;
`ifdef ECHO_JITTER_EN
    b = b + int'(lfsr_m[3:0]);
    if (b > TO) b = TO;
`endif
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive trigger high for n sampled cycles, then low. If the pulse qualifies, push the
  // expected echo width and latency.
  task automatic pulse(input int n, input int d, input bit qualifies);
    step();
    dist_cycles = 32'(d);
    trigger = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    if (qualifies) begin
      exp_w.push_back(model_width(d));
      exp_lat.push_back(LAT);
`ifdef ECHO_JITTER_EN
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
    end
    trigger = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic wait_idle(input string name, output int at);
    int n;
    n = 0;
    at = -1;
    while (n < 3000) begin
      @(negedge clk);
      if (!busy) begin
        at = cyc;
        break;
      end
      n++;
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL %s_idle_timeout got busy=%0b want 0 within 3000 cycles", name, busy);
    end
  endtask

  task automatic wait_echo(input string name);
    int n;
    n = 0;
    while (!echo && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!echo) begin
      checks++; errors++;
      $display("FAIL %s_echo_timeout got echo=%0b want 1 within 200 cycles", name, echo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    trigger = 1'b0;
    dist_cycles = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({echo, burst, busy, trig_err, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000", {echo, burst, busy, trig_err, done});
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int at;
    burst_rises = 0;
    pulse(TRIG_MIN, 300, 1'b1);
    step();
    dist_cycles = 32'd7;   // changes after sampling must not affect this measurement
    wait_idle("basic", at);
    checks++;
    if (burst_rises !== 8) begin
      errors++;
      $display("FAIL burst_pulses got %0d want 8", burst_rises);
    end
    checks++;
    if (at - echo_fall_cyc !== HOLD) begin
      errors++;
      $display("FAIL holdoff_len got %0d want %0d", at - echo_fall_cyc, HOLD);
    end
    checks++;
    if (exp_w.size() !== 0) begin
      errors++;
      $display("FAIL basic_pending got %0d want 0", exp_w.size());
    end
  endtask

  task automatic test_short_trigger();
    int bad;
    pulse(TRIG_MIN - 1, 300, 1'b0);
    @(negedge clk);
    checks++;
    if ({trig_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL short_before got trig_err,busy=%b want 01", {trig_err, busy});
    end
    @(negedge clk);
    checks++;
    if ({trig_err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL short_err got trig_err,busy=%b want 10", {trig_err, busy});
    end
    @(negedge clk);
    checks++;
    if (trig_err !== 1'b0) begin
      errors++;
      $display("FAIL short_err_len got %0b want 0", trig_err);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (burst || echo || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL short_quiet got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_clamp();
    int at;
    pulse(TRIG_MIN, 0, 1'b1);
    wait_idle("clamp0", at);
    pulse(TRIG_MIN, 5000, 1'b1);
    wait_idle("clamp5000", at);
    pulse(TRIG_MIN, TO, 1'b1);
    wait_idle("clampmax", at);
    checks++;
    if (exp_w.size() !== 0) begin
      errors++;
      $display("FAIL clamp_pending got %0d want 0", exp_w.size());
    end
  endtask

  task automatic test_retrigger();
    int at, bad;
    pulse(TRIG_MIN, TO, 1'b1);
    wait_echo("retrig");
    repeat (50) step();
    trigger = 1'b1;
    repeat (600) step();
    trigger = 1'b0;
    repeat (20) step();
    trigger = 1'b1;          // held high through HOLDOFF into IDLE
    wait_idle("retrig", at);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL held_trigger_ignored got %0d busy cycles want 0", bad);
    end
    step();
    trigger = 1'b0;
    pulse(TRIG_MIN, 50, 1'b1);
    wait_idle("retrig2", at);
    checks++;
    if (exp_w.size() !== 0) begin
      errors++;
      $display("FAIL retrig_pending got %0d want 0", exp_w.size());
    end
  endtask

  task automatic test_reset_mid_echo();
    int at;
    pulse(TRIG_MIN, 300, 1'b1);
    wait_echo("rstmid");
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({echo, busy, burst} !== 3'b000) begin
      errors++;
      $display("FAIL reset_immediate got echo,busy,burst=%b want 000", {echo, busy, burst});
    end
`ifdef ECHO_JITTER_EN
    lfsr_m = 16'hACE1;
`endif
    step();
    step();
    checks++;
    if (exp_w.size() !== 0) begin
      errors++;
      $display("FAIL reset_pending got %0d want 0", exp_w.size());
    end
    rst_n = 1'b1;
    pulse(TRIG_MIN, 20, 1'b1);
    wait_idle("rstmid2", at);
    checks++;
    if (exp_w.size() !== 0) begin
      errors++;
      $display("FAIL after_reset_pending got %0d want 0", exp_w.size());
    end
  endtask

`ifdef ECHO_JITTER_EN
  task automatic test_jitter();
    int at;
    obs_w.delete();
    pulse(TRIG_MIN, 100, 1'b1);
    wait_idle("jit1", at);
    pulse(TRIG_MIN, 100, 1'b1);
    wait_idle("jit2", at);
    checks++;
    if (obs_w.size() !== 2 || obs_w[0] == obs_w[1]) begin
      errors++;
      $display("FAIL jitter_differs got %0d widths want 2 distinct", obs_w.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_short_trigger();
    test_clamp();
    test_retrigger();
    test_reset_mid_echo();
`ifdef ECHO_JITTER_EN
    test_jitter();
`endif
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no finish want finish before 5 ms");
    $fatal(1, "watchdog");
  end

endmodule
